// File: rtl/iterative_divider.sv
// ============================================================================
//  iterative_divider
//  Multi-cycle restoring radix-2 divide/remainder unit for RV M-extension
//  (DIV/DIVU/REM/REMU and W variants in 64-bit builds).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module iterative_divider #(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Start,
  input  logic                 Flush,
  input  logic [1:0]           DivOperation,
  input  logic                 WordOp,
  input  logic [BIT_COUNT-1:0] DivOperandA,
  input  logic [BIT_COUNT-1:0] DivOperandB,
  output logic                 Busy,
  output logic                 Done,
  output logic                 DivByZero,
  output logic [BIT_COUNT-1:0] DivResult
);

  localparam int CW = $clog2(BIT_COUNT + 1);
  localparam bit WIDE = (BIT_COUNT > WORD_SIZE);
  localparam logic [BIT_COUNT-1:0] MIN_FULL = BIT_COUNT'(1) << (BIT_COUNT - 1);
  localparam logic [BIT_COUNT-1:0] MIN_WORD =
    ~((BIT_COUNT'(1) << (WORD_SIZE - 1)) - BIT_COUNT'(1));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREP    = 3'd1,
    S_ITERATE = 3'd2,
    S_FIXUP   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state;
  logic [1:0]           op;
  logic                 word;
  logic [BIT_COUNT-1:0] opa;     // dividend, then shifting dividend/quotient
  logic [BIT_COUNT-1:0] opb;     // divisor, then divisor magnitude
  logic [BIT_COUNT-1:0] rem;
  logic [CW-1:0]        cnt;
  logic                 neg_q;
  logic                 neg_r;

  // Sign-extend the low word to the full datapath width
  function automatic logic [BIT_COUNT-1:0] sext_w(input logic [WORD_SIZE-1:0] x);
    logic [BIT_COUNT-1:0] r;
    r = {BIT_COUNT{x[WORD_SIZE-1]}};
    r[WORD_SIZE-1:0] = x;
    return r;
  endfunction

  logic                 signed_op;
  logic                 w_word;
  logic [BIT_COUNT-1:0] a_ext;
  logic [BIT_COUNT-1:0] b_ext;
  logic                 sign_a;
  logic                 sign_b;
  logic [BIT_COUNT-1:0] mag_a;
  logic [BIT_COUNT-1:0] mag_b;
  logic                 b_zero;
  logic                 ovf;
  logic [BIT_COUNT-1:0] a_out;
  logic [BIT_COUNT-1:0] special_res;
  logic [BIT_COUNT-1:0] dvd_init;
  logic [CW-1:0]        cnt_init;
  logic [BIT_COUNT:0]   shifted;
  logic                 qbit;
  logic [BIT_COUNT-1:0] sub;
  logic [BIT_COUNT-1:0] q_raw;
  logic [BIT_COUNT-1:0] q_fix;
  logic [BIT_COUNT-1:0] r_fix;
  logic [BIT_COUNT-1:0] sel_res;
  logic [BIT_COUNT-1:0] fix_res;

  // Operand preparation, one iteration step and final sign/select fixup
  always_comb begin
    signed_op = ~op[0];
    w_word    = word && WIDE;

    // Truncate to the effective width, then extend according to signedness
    if (w_word) begin
      a_ext = signed_op ? sext_w(opa[WORD_SIZE-1:0]) : BIT_COUNT'(opa[WORD_SIZE-1:0]);
      b_ext = signed_op ? sext_w(opb[WORD_SIZE-1:0]) : BIT_COUNT'(opb[WORD_SIZE-1:0]);
      sign_a = signed_op & opa[WORD_SIZE-1];
      sign_b = signed_op & opb[WORD_SIZE-1];
      a_out  = sext_w(opa[WORD_SIZE-1:0]);
    end else begin
      a_ext  = opa;
      b_ext  = opb;
      sign_a = signed_op & opa[BIT_COUNT-1];
      sign_b = signed_op & opb[BIT_COUNT-1];
      a_out  = opa;
    end

    mag_a  = sign_a ? -a_ext : a_ext;
    mag_b  = sign_b ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = signed_op && (a_ext == (w_word ? MIN_WORD : MIN_FULL)) && (&b_ext);

    if (b_zero) special_res = op[1] ? a_out : '1;
    else        special_res = op[1] ? '0 : a_out;

    // W operands are left-aligned so the iteration always consumes the MSB
    dvd_init = w_word ? (mag_a << (BIT_COUNT - WORD_SIZE)) : mag_a;
    cnt_init = w_word ? CW'(WORD_SIZE) : CW'(BIT_COUNT);

    shifted = {rem, opa[BIT_COUNT-1]};
    qbit    = (shifted >= {1'b0, opb});
    sub     = shifted[BIT_COUNT-1:0] - opb;

    q_raw   = w_word ? BIT_COUNT'(opa[WORD_SIZE-1:0]) : opa;
    q_fix   = neg_q ? -q_raw : q_raw;
    r_fix   = neg_r ? -rem : rem;
    sel_res = op[1] ? r_fix : q_fix;
    fix_res = w_word ? sext_w(sel_res[WORD_SIZE-1:0]) : sel_res;
  end

  // Control FSM and datapath registers; Flush overrides every transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op        <= '0;
      word      <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      rem       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      DivResult <= '0;
    end else if (Flush) begin
      state     <= S_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            op    <= DivOperation;
            word  <= WordOp;
            opa   <= DivOperandA;
            opb   <= DivOperandB;
            Busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q <= sign_a ^ sign_b;
          neg_r <= sign_a;
          if (b_zero || ovf) begin
            DivResult <= special_res;
            DivByZero <= b_zero;
            Done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            opa   <= dvd_init;
            opb   <= mag_b;
            rem   <= '0;
            cnt   <= cnt_init;
            state <= S_ITERATE;
          end
        end
        S_ITERATE: begin
          rem <= qbit ? sub : shifted[BIT_COUNT-1:0];
          opa <= {opa[BIT_COUNT-2:0], qbit};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          DivResult <= fix_res;
          Done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          Done      <= 1'b0;
          DivByZero <= 1'b0;
          Busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          Done      <= 1'b0;
          DivByZero <= 1'b0;
          Busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider.sv
// ============================================================================
//  tb_iterative_divider
//  Self-checking bench for iterative_divider: 32-bit and 64-bit instances,
//  directed vector table, hand sequences and randomized reference checks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic        word;
  logic        sel;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;

  logic        start32, start64;
  logic        busy32, done32, dbz32;
  logic [31:0] res32;
  logic        busy64, done64, dbz64;
  logic [63:0] res64;
  logic        cur_busy, cur_done, cur_dbz;
  logic [63:0] cur_res;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start32  = start & ~sel;
  assign start64  = start & sel;
  assign cur_busy = sel ? busy64 : busy32;
  assign cur_done = sel ? done64 : done32;
  assign cur_dbz  = sel ? dbz64 : dbz32;
  assign cur_res  = sel ? res64 : {32'b0, res32};

  iterative_divider #(.BIT_COUNT(32), .WORD_SIZE(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .Start(start32), .Flush(flush),
    .DivOperation(op), .WordOp(word),
    .DivOperandA(a[31:0]), .DivOperandB(b[31:0]),
    .Busy(busy32), .Done(done32), .DivByZero(dbz32), .DivResult(res32)
  );

  iterative_divider #(.BIT_COUNT(64), .WORD_SIZE(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .Start(start64), .Flush(flush),
    .DivOperation(op), .WordOp(word),
    .DivOperandA(a), .DivOperandB(b),
    .Busy(busy64), .Done(done64), .DivByZero(dbz64), .DivResult(res64)
  );

  typedef struct {
    bit          wide;
    logic [1:0]  op;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    bit          dbz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: RISC-V division rules using plain arithmetic
  function automatic void ref_model(input bit wide, input logic [1:0] o, input bit w,
                                    input logic [63:0] av, input logic [63:0] bv,
                                    output logic [63:0] res, output bit dbz, output int lat);
    int          wd;
    int          ta, tb;
    longint      sa, sb, min_v;
    logic [63:0] ua, ub, q, r, v;
    bit          ovf;
    wd = (wide && !w) ? 64 : 32;
    if (wd == 32) begin
      ua = {32'b0, av[31:0]};
      ub = {32'b0, bv[31:0]};
      ta = av[31:0];
      tb = bv[31:0];
      sa = ta;
      sb = tb;
      min_v = -(longint'(1) <<< 31);
    end else begin
      ua = av;
      ub = bv;
      sa = av;
      sb = bv;
      min_v = longint'(64'h8000_0000_0000_0000);
    end
    dbz = (ub == 64'd0);
    ovf = !o[0] && !dbz && (sb == -1) && (sa == min_v);
    if (dbz) begin
      q = '1;
      r = ua;
    end else if (ovf) begin
      q = ua;
      r = 64'd0;
    end else if (!o[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    v = o[1] ? r : q;
    if (wd == 32) v = wide ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
    res = v;
    lat = (dbz || ovf) ? 2 : wd + 3;
  endfunction

  task automatic launch(input bit wide, input logic [1:0] o, input bit w,
                        input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    sel = wide; op = o; word = w; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles (relative to the accept cycle) until Done, with a bound
  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (1'b1) begin
      if (cur_busy) bc++;
      if (cur_done || lat >= 150) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string nm, input bit wide, input logic [1:0] o, input bit w,
                           input logic [63:0] av, input logic [63:0] bv,
                           input logic [63:0] er, input bit ez, input int el);
    int lat, bc;
    launch(wide, o, w, av, bv);
    wait_done(1, lat, bc);
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " result"}, cur_res, er);
    chk({nm, " divbyzero"}, {63'b0, cur_dbz}, {63'b0, ez});
    chk({nm, " busy cycles"}, 64'(bc), 64'(el));
    @(negedge clk);
    chk({nm, " done pulse"}, {63'b0, cur_done}, 64'd0);
    chk({nm, " busy after"}, {63'b0, cur_busy}, 64'd0);
  endtask

  vec_t vt[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, bc, seen;
    logic [63:0] er;
    bit          ez;
    int          el;
    bit          rw, rword;
    logic [1:0]  ro;
    logic [63:0] ra, rb;

    vt[0]  = '{0, 2'b01, 0, 64'd100, 64'd7, 64'd14, 0, 35};
    vt[1]  = '{0, 2'b11, 0, 64'd100, 64'd7, 64'd2, 0, 35};
    vt[2]  = '{0, 2'b00, 0, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFF2, 0, 35};
    vt[3]  = '{0, 2'b10, 0, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFFE, 0, 35};
    vt[4]  = '{0, 2'b00, 0, 64'd5, 64'd0, 64'hFFFF_FFFF, 1, 2};
    vt[5]  = '{0, 2'b11, 0, 64'd5, 64'd0, 64'd5, 1, 2};
    vt[6]  = '{0, 2'b00, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0, 2};
    vt[7]  = '{0, 2'b10, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0, 2};
    vt[8]  = '{0, 2'b00, 0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFFE, 0, 35};
    vt[9]  = '{0, 2'b01, 1, 64'd100, 64'd7, 64'd14, 0, 35};
    vt[10] = '{1, 2'b01, 1, 64'h0000_0001_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 35};
    vt[11] = '{1, 2'b00, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 67};
    vt[12] = '{1, 2'b10, 1, 64'h1234_5678_8000_0005, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0005, 1, 2};
    vt[13] = '{1, 2'b00, 1, 64'h0000_ABCD_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 0, 2};

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; word = 1'b0; sel = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy32", {63'b0, busy32}, 64'd0);
    chk("reset done32", {63'b0, done32}, 64'd0);
    chk("reset dbz32", {63'b0, dbz32}, 64'd0);
    chk("reset res32", {32'b0, res32}, 64'd0);
    chk("reset busy64", {63'b0, busy64}, 64'd0);
    chk("reset res64", res64, 64'd0);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++)
      run_check($sformatf("vec%0d", i), vt[i].wide, vt[i].op, vt[i].w,
                vt[i].a, vt[i].b, vt[i].res, vt[i].dbz, vt[i].lat);
    run_check("vec64 remu", 1, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
              64'h0000_0000_FFFF_FFFF, 0, 67);
    run_check("vec64 ovf", 1, 2'b00, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 0, 2);

    // Start while busy is ignored and operands are not re-latched
    launch(0, 2'b01, 0, 64'd100, 64'd7);
    repeat (3) @(negedge clk);
    op = 2'b11; a = 64'd50; b = 64'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, bc);
    chk("busy start latency", 64'(lat), 64'd35);
    chk("busy start result", cur_res, 64'd14);

    // Start held through the Done cycle is taken only once back in IDLE
    @(negedge clk);
    sel = 1'b0; op = 2'b00; word = 1'b0; a = 64'd5; b = 64'd0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold start done", {63'b0, cur_done}, 64'd1);
    op = 2'b01; a = 64'd9; b = 64'd3;
    @(negedge clk);
    chk("start in done ignored", {63'b0, cur_busy}, 64'd0);
    @(negedge clk);
    chk("start after done taken", {63'b0, cur_busy}, 64'd1);
    start = 1'b0;
    wait_done(1, lat, bc);
    chk("after done latency", 64'(lat), 64'd35);
    chk("after done result", cur_res, 64'd3);
    chk("after done dbz", {63'b0, cur_dbz}, 64'd0);

    // Flush during iteration 10 aborts without Done and keeps DivResult
    run_check("pre flush", 0, 2'b01, 0, 64'd77, 64'd7, 64'd11, 0, 35);
    launch(0, 2'b01, 0, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {63'b0, cur_busy}, 64'd0);
    chk("flush done", {63'b0, cur_done}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (cur_done) seen++;
    end
    chk("flush no done", 64'(seen), 64'd0);
    chk("flush result kept", cur_res, 64'd11);
    run_check("post flush", 0, 2'b01, 0, 64'd9, 64'd3, 64'd3, 0, 35);

    // Flush together with Start in IDLE drops the Start
    @(negedge clk);
    sel = 1'b0; op = 2'b01; a = 64'd9; b = 64'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", {63'b0, cur_busy}, 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      rw    = (i >= 30);
      ro    = 2'($urandom_range(0, 3));
      rword = 1'($urandom_range(0, 1));
      ra    = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rb = 64'd0;
        1:       rb = '1;
        2:       rb = 64'($urandom_range(1, 15));
        3:       rb = {32'b0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0)
        ra = (rw && !rword) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      ref_model(rw, ro, rword, ra, rb, er, ez, el);
      run_check($sformatf("rand%0d", i), rw, ro, rword, ra, rb, er, ez, el);
    end

    // Reset mid-iteration clears every output immediately
    launch(1, 2'b01, 0, 64'd100, 64'd7);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async rst busy64", {63'b0, busy64}, 64'd0);
    chk("async rst done64", {63'b0, done64}, 64'd0);
    chk("async rst dbz64", {63'b0, dbz64}, 64'd0);
    chk("async rst res64", res64, 64'd0);
    chk("async rst res32", {32'b0, res32}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done64 || busy64) seen++;
    end
    chk("no done after reset", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle integer divide/remainder unit for the RV M-extension (DIV, DIVU, REM, REMU and, for 64-bit builds, DIVW/DIVUW/REMW/REMUW).
- Sits in the computational stage beside the single-cycle ALU and takes the same operands from the forwarding muxes.
- Uses restoring radix-2 division with a start/busy/done handshake; the hazard unit stalls the pipeline while Busy is high.

Parameters:
- BIT_COUNT, 32, datapath width; legal values are 32 and 64.
- WORD_SIZE, 32, width used for W-variant operations; only meaningful when BIT_COUNT=64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; accepted only in IDLE.
- Flush  input  1  abort the in-flight operation (pipeline flush).
- DivOperation  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- WordOp  input  1  selects 32-bit W variant; ignored (treated as 0) when BIT_COUNT=32.
- DivOperandA  input  BIT_COUNT  dividend.
- DivOperandB  input  BIT_COUNT  divisor.
- Busy  output  1  high in every non-IDLE state.
- Done  output  1  one-cycle pulse; DivResult is valid in this cycle.
- DivByZero  output  1  high alongside Done when the divisor was zero.
- DivResult  output  BIT_COUNT  quotient or remainder; holds its value until the next accepted Start.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; Busy=0, Done=0, DivByZero=0, DivResult=0.
  - Internal quotient, remainder, counter and sign flags are cleared.
- States: IDLE, PREP, ITERATE, FIXUP, DONE.
- IDLE:
  - Start=1 latches DivOperation, WordOp, A and B, then moves to PREP.
  - Busy goes high the next cycle.
- PREP (1 cycle):
  - Effective width is 32 if WordOp, else BIT_COUNT; operands are truncated to that width.
  - Signed ops (DIV/REM): record signA and signB, replace operands by their magnitudes.
  - Divisor==0: DivResult = all-ones quotient (DIV/DIVU), or dividend (REM/REMU) sign-extended per WordOp. DivByZero=1; go to DONE.
  - Signed overflow (A = most-negative of the effective width, B = -1): DivResult = A for DIV, 0 for REM. DivByZero=0; go to DONE.
  - Otherwise: load counter = effective width, remainder = 0; go to ITERATE.
- ITERATE (one quotient bit per cycle):
  - Shift {remainder, dividend} left by 1; trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement the counter; go to FIXUP when the counter reaches 1 (i.e. after exactly "effective width" iterations).
- FIXUP (1 cycle):
  - Signed ops: negate the quotient if signA^signB; negate the remainder if signA (remainder takes the dividend's sign).
  - Select quotient or remainder per DivOperation.
  - WordOp: sign-extend bit 31 into the upper WORD_SIZE bits, including for unsigned W ops (RV64 rule).
  - Register the result into DivResult; go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. DivByZero is valid only while Done=1 and is cleared on leaving DONE.
- Latency, with Start accepted in cycle N:
  - Normal op: Done in cycle N+3+W (W = effective width), i.e. 35 cycles for 32-bit, 67 for 64-bit.
  - Special case (divisor zero or signed overflow): Done in cycle N+2.
- Start while Busy: ignored; operands are not re-latched.
- Start in the same cycle that Done=1: ignored; it is accepted the following cycle in IDLE.
- Flush:
  - Synchronous; it has priority over all transitions.
  - Any state goes to IDLE next cycle; Done is suppressed; DivResult keeps its prior value.
  - Flush together with Start in IDLE: Start is dropped.
- reset_n asserted mid-operation: immediate return to the reset values; no Done is produced.
- Back-to-back operations: a new Start is accepted one cycle after Done, with no residual state carried over.

Test Plan:
- Start DIVU, A=100, B=7, BIT_COUNT=32 -> Busy high for 35 cycles; Done in cycle N+35; DivResult=14, DivByZero=0. Repeat with REMU -> DivResult=2.
- Start DIV, A=-100 (0xFFFFFF9C), B=7 -> DivResult=0xFFFFFFF2 (-14). REM -> 0xFFFFFFFE (-2).
- Start DIV with B=0, A=5 -> Done in cycle N+2; DivResult=0xFFFFFFFF, DivByZero=1. REMU with B=0 -> DivResult=5.
- Start DIV, A=0x80000000, B=0xFFFFFFFF -> Done in cycle N+2; DivResult=0x80000000. REM -> 0, DivByZero=0.
- Assert Flush at iteration 10 of a DIVU, then Start DIVU A=9, B=3 -> no Done for the aborted op; second op gives Done with DivResult=3. Also assert reset_n=0 mid-ITERATE -> all outputs 0 immediately.
- BIT_COUNT=64, WordOp=1, DIVUW, A=0x00000001_FFFFFFFE, B=1 -> Done in cycle N+35; DivResult=0xFFFFFFFF_FFFFFFFE (low 32 bits divided, result sign-extended).
